// File: rtl/alu_flag_unit_if.sv
// Flag-unit bus: ALU flag writeback, shadow save/restore, condition query and result handshake.
// The core side drives through master; the flag unit consumes through slave.
interface alu_flag_unit_if;
    logic [3:0] alu_flags;
    logic       flag_we;
    logic       flag_save;
    logic       flag_restore;
    logic       cond_valid;
    logic [3:0] cond_code;
    logic       cond_ready;
    logic       out_valid;
    logic       out_ready;
    logic       out_taken;
    logic [3:0] out_code;
    logic [3:0] flags;

    modport master (
        output alu_flags, flag_we, flag_save, flag_restore, cond_valid, cond_code, out_ready,
        input  cond_ready, out_valid, out_taken, out_code, flags
    );

    modport slave (
        input  alu_flags, flag_we, flag_save, flag_restore, cond_valid, cond_code, out_ready,
        output cond_ready, out_valid, out_taken, out_code, flags
    );
endinterface

// File: rtl/alu_flag_unit.sv
// {v,c,n,z} flag register with shadow save/restore and condition evaluation; 1-cycle result latency.
// One-entry output register: cond_ready drops while a result is held and out_ready is low.
module alu_flag_unit #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000,
    parameter bit         HAS_SHADOW  = 1'b1
) (
    input  logic           clk,
    input  logic           reset_n,
    alu_flag_unit_if.slave bus
);

    logic [3:0] flags_q;
    logic [3:0] shadow_q;
    logic [3:0] nf;
    logic       accept;
    logic       cond_ready;
    logic       out_valid_q;
    logic       out_taken_q;
    logic [3:0] out_code_q;
    logic       taken_now;

    function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
        logic v, c, n, z;
        v = f[3];
        c = f[2];
        n = f[1];
        z = f[0];
        case (code)
            4'h0:    eval_cond = z;
            4'h1:    eval_cond = ~z;
            4'h2:    eval_cond = c;
            4'h3:    eval_cond = ~c;
            4'h4:    eval_cond = n;
            4'h5:    eval_cond = ~n;
            4'h6:    eval_cond = v;
            4'h7:    eval_cond = ~v;
            4'h8:    eval_cond = c & ~z;
            4'h9:    eval_cond = ~c | z;
            4'hA:    eval_cond = (n == v);
            4'hB:    eval_cond = (n != v);
            4'hC:    eval_cond = ~z & (n == v);
            4'hD:    eval_cond = z | (n != v);
            4'hE:    eval_cond = 1'b1;
            default: eval_cond = 1'b0;
        endcase
    endfunction

    // Queries see this cycle's flag update, so a compare and its branch can share a cycle.
    always_comb begin
        nf = flags_q;
        if (HAS_SHADOW && bus.flag_restore) begin
            nf = shadow_q;
        end else if (bus.flag_we) begin
            nf = bus.alu_flags;
        end
    end

    assign cond_ready = ~out_valid_q | bus.out_ready;
    assign accept     = bus.cond_valid & cond_ready;
    assign taken_now  = eval_cond(bus.cond_code, nf);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q     <= RESET_FLAGS;
            shadow_q    <= RESET_FLAGS;
            out_valid_q <= 1'b0;
            out_taken_q <= 1'b0;
            out_code_q  <= 4'h0;
        end else begin
            flags_q <= nf;
            // Saves the pre-update value, so save+restore in one cycle swaps the two registers.
            if (HAS_SHADOW && bus.flag_save) begin
                shadow_q <= flags_q;
            end
            if (accept) begin
                out_valid_q <= 1'b1;
                out_taken_q <= taken_now;
                out_code_q  <= bus.cond_code;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.cond_ready = cond_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_taken  = out_taken_q;
    assign bus.out_code   = out_code_q;
    assign bus.flags      = flags_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Bench for alu_flag_unit: truth-table sweep, directed handshake/shadow/reset sequences,
// then random traffic against a queue-based reference model.
module tb_alu_flag_unit;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    alu_flag_unit_if bus ();

    alu_flag_unit #(
        .RESET_FLAGS(4'b0101),
        .HAS_SHADOW (1'b1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    // Expected taken bit for every flag value {v,c,n,z} = index 0..15, one mask per code.
    typedef struct {
        logic [3:0]  code;
        logic [15:0] taken_mask;
    } vec_t;
    vec_t vecs [16];

    logic [3:0] m_flags;
    logic [3:0] m_shadow;
    logic [4:0] m_q[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_taken(input logic [3:0] code, input logic [3:0] f);
        logic [15:0] m;
        m = vecs[code].taken_mask;
        return m[f];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_flags    = 4'h0;
        bus.flag_we      = 1'b0;
        bus.flag_save    = 1'b0;
        bus.flag_restore = 1'b0;
        bus.cond_valid   = 1'b0;
        bus.cond_code    = 4'h0;
    endtask

    task automatic write_flags(input logic [3:0] f);
        idle();
        bus.flag_we   = 1'b1;
        bus.alu_flags = f;
        cyc();
    endtask

    initial begin
        vecs[0]  = '{4'h0, 16'hAAAA};
        vecs[1]  = '{4'h1, 16'h5555};
        vecs[2]  = '{4'h2, 16'hF0F0};
        vecs[3]  = '{4'h3, 16'h0F0F};
        vecs[4]  = '{4'h4, 16'hCCCC};
        vecs[5]  = '{4'h5, 16'h3333};
        vecs[6]  = '{4'h6, 16'hFF00};
        vecs[7]  = '{4'h7, 16'h00FF};
        vecs[8]  = '{4'h8, 16'h5050};
        vecs[9]  = '{4'h9, 16'hAFAF};
        vecs[10] = '{4'hA, 16'hCC33};
        vecs[11] = '{4'hB, 16'h33CC};
        vecs[12] = '{4'hC, 16'h4411};
        vecs[13] = '{4'hD, 16'hBBEE};
        vecs[14] = '{4'hE, 16'hFFFF};
        vecs[15] = '{4'hF, 16'h0000};

        // Reset state
        idle();
        bus.out_ready = 1'b1;
        reset_n = 1'b0;
        cyc();
        cyc();
        chk("reset_flags", bus.flags, 4'b0101);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_cond_ready", bus.cond_ready, 1);
        chk("reset_out_taken", bus.out_taken, 0);
        chk("reset_out_code", bus.out_code, 0);
        reset_n = 1'b1;

        // Forwarded flag write plus EQ query in the same cycle
        idle();
        bus.flag_we    = 1'b1;
        bus.alu_flags  = 4'b0001;
        bus.cond_valid = 1'b1;
        bus.cond_code  = 4'h0;
        cyc();
        chk("fwd_out_valid", bus.out_valid, 1);
        chk("fwd_out_taken", bus.out_taken, 1);
        chk("fwd_out_code", bus.out_code, 0);
        chk("fwd_flags", bus.flags, 4'b0001);

        // Full code x flags sweep, one result per cycle
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                bus.flag_we    = 1'b1;
                bus.alu_flags  = 4'(f);
                bus.cond_valid = 1'b1;
                bus.cond_code  = vecs[c].code;
                cyc();
                chk($sformatf("sweep_taken_c%0h_f%0h", c, f), bus.out_taken, vecs[c].taken_mask[f]);
                chk($sformatf("sweep_code_c%0h_f%0h", c, f), bus.out_code, vecs[c].code);
            end
        end
        idle();
        cyc();
        chk("drain_out_valid", bus.out_valid, 0);

        // Backpressure: hold one result for 3 cycles while flags keep changing
        bus.out_ready  = 1'b0;
        bus.cond_valid = 1'b1;
        bus.cond_code  = 4'hE;
        cyc();
        for (int i = 0; i < 3; i++) begin
            bus.cond_code = 4'hF;
            bus.flag_we   = 1'b1;
            bus.alu_flags = 4'(i + 8);
            #1;
            chk("stall_cond_ready", bus.cond_ready, 0);
            cyc();
            chk("stall_out_valid", bus.out_valid, 1);
            chk("stall_out_taken", bus.out_taken, 1);
            chk("stall_out_code", bus.out_code, 4'hE);
            chk("stall_flags", bus.flags, i + 8);
        end
        bus.flag_we   = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("release_cond_ready", bus.cond_ready, 1);
        cyc();
        chk("b2b_out_valid", bus.out_valid, 1);
        chk("b2b_out_taken", bus.out_taken, 0);
        chk("b2b_out_code", bus.out_code, 4'hF);
        idle();
        cyc();
        chk("consume_out_valid", bus.out_valid, 0);

        // Shadow save / restore / swap / restore-vs-write priority
        write_flags(4'b0010);
        idle();
        bus.flag_save = 1'b1;
        cyc();
        write_flags(4'b1101);
        chk("after_save_write", bus.flags, 4'b1101);
        idle();
        bus.flag_restore = 1'b1;
        cyc();
        chk("restore_flags", bus.flags, 4'b0010);
        write_flags(4'b0111);
        idle();
        bus.flag_save    = 1'b1;
        bus.flag_restore = 1'b1;
        cyc();
        chk("swap_flags", bus.flags, 4'b0010);
        idle();
        bus.flag_restore = 1'b1;
        cyc();
        chk("swap_shadow", bus.flags, 4'b0111);
        write_flags(4'b0011);
        idle();
        bus.flag_restore = 1'b1;
        bus.flag_we      = 1'b1;
        bus.alu_flags    = 4'b1111;
        cyc();
        chk("restore_beats_we", bus.flags, 4'b0111);

        // Reset while a result is stalled
        idle();
        bus.out_ready  = 1'b0;
        bus.cond_valid = 1'b1;
        bus.cond_code  = 4'hE;
        cyc();
        chk("pre_reset_valid", bus.out_valid, 1);
        reset_n = 1'b0;
        cyc();
        chk("stall_reset_valid", bus.out_valid, 0);
        chk("stall_reset_flags", bus.flags, 4'b0101);
        idle();
        reset_n = 1'b1;
        m_flags  = 4'b0101;
        m_shadow = 4'b0101;
        m_q.delete();

        // Random traffic vs reference model
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] nf;
            logic       rdy;
            bus.alu_flags    = 4'($urandom);
            bus.flag_we      = ($urandom_range(0, 1) == 1);
            bus.flag_save    = ($urandom_range(0, 7) == 0);
            bus.flag_restore = ($urandom_range(0, 7) == 0);
            bus.cond_valid   = ($urandom_range(0, 3) != 0);
            bus.cond_code    = 4'($urandom);
            bus.out_ready    = ($urandom_range(0, 3) != 0);
            #1;
            rdy = (m_q.size() == 0) || bus.out_ready;
            chk("rnd_cond_ready", bus.cond_ready, rdy);
            if (bus.out_ready && m_q.size() != 0) void'(m_q.pop_front());
            nf = bus.flag_restore ? m_shadow : (bus.flag_we ? bus.alu_flags : m_flags);
            if (bus.cond_valid && rdy) m_q.push_back({model_taken(bus.cond_code, nf), bus.cond_code});
            if (bus.flag_save) m_shadow = m_flags;
            m_flags = nf;
            cyc();
            chk("rnd_flags", bus.flags, m_flags);
            chk("rnd_out_valid", bus.out_valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                chk("rnd_out_taken", bus.out_taken, m_q[0][4]);
                chk("rnd_out_code", bus.out_code, m_q[0][3:0]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
